// File: rtl/uart_tx_parity.sv
// UART transmitter with an optional even-parity bit.
// A word accepted through the valid/ready handshake is sent LSB-first as a
// start bit, the data bits, an optional parity bit and one or two stop bits.
// Each bit lasts CLKS_PER_BIT clocks. Every output comes straight from a flop,
// so serial_out can drive the pad directly.
module uart_tx_parity #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int CLKS_PER_BIT     = 16,
   parameter int PARITY_EN        = 1,
   parameter int STOP_BITS        = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        serial_out,
   output logic                        tx_busy,
   output logic                        is_parity_stage
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(INPUT_DATA_WIDTH - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               baud_q, baud_d;
   logic [BW-1:0]               bit_q, bit_d;
   logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
   logic                        parity_q, parity_d;
   logic                        stop_q, stop_d;
   logic                        serial_q, serial_d;
   logic                        ready_q, ready_d;
   logic                        busy_q, busy_d;
   logic                        par_stage_q, par_stage_d;
   logic                        bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         stop_q      <= 1'b0;
         serial_q    <= 1'b1;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         par_stage_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         stop_q      <= stop_d;
         serial_q    <= serial_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         par_stage_q <= par_stage_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so the flops
   // present the new line level on the same edge the state changes.
   always_comb begin
      state_d  = state_q;
      baud_d   = bit_end ? '0 : baud_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      stop_d   = stop_q;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (tx_valid && ready_q) begin
               shift_d  = tx_data;
               parity_d = ^tx_data;
               bit_d    = '0;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  stop_d  = 1'b0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               stop_d  = 1'b0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      serial_d    = 1'b1;
      ready_d     = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      par_stage_d = (state_d == PARITY);
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         PARITY:  serial_d = parity_d;
         default: serial_d = 1'b1;
      endcase
   end

   assign tx_ready        = ready_q;
   assign serial_out      = serial_q;
   assign tx_busy         = busy_q;
   assign is_parity_stage = par_stage_q;

endmodule
